// File: rtl/pipe_div_pkg.sv
// Shared types and helpers for the parametrised pipelined divider.
// Optional feature macro: PIPE_DIV_REMAINDER_EN (remainder output path).
package pipe_div_pkg;

  localparam int unsigned DEF_DW  = 28;
  localparam int unsigned DEF_VW  = 20;
  localparam int unsigned DEF_QW  = 8;
  localparam int unsigned DEF_BPS = 1;
  localparam int unsigned DEF_TW  = 4;

  // Result-flag encodings, {div0, ovf}
  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_OVF  = 2'b01;
  localparam logic [1:0] FLAG_DIV0 = 2'b10;

  typedef struct packed {
    logic div0;
    logic ovf;
  } div_flags_t;

  // Number of pipeline stages for a quotient width and bits-per-stage
  function automatic int unsigned num_stages(input int unsigned qw, input int unsigned bps);
    return qw / bps;
  endfunction

  // Partial-remainder width: one guard bit above the dividend
  function automatic int unsigned pr_width(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/pipe_div_stage.sv
// One restoring-division stage: resolves BPS quotient bits and registers the
// partial remainder, divisor, quotient, tag and flags under a shared enable.
// KEEP_R=0 drops the partial-remainder register (used for the last stage when
// the remainder output is not built, PIPE_DIV_REMAINDER_EN undefined).
module pipe_div_stage
  import pipe_div_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned VW     = DEF_VW,
  parameter int unsigned QW     = DEF_QW,
  parameter int unsigned BPS    = DEF_BPS,
  parameter int unsigned TW     = DEF_TW,
  parameter int unsigned STAGE  = 0,
  parameter bit          KEEP_R = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_en,
  input  logic                   i_valid,
  input  logic [DW:0]            i_r,
  input  logic [VW-1:0]          i_d,
  input  logic [QW-1:0]          i_q,
  input  logic [TW-1:0]          i_tag,
  input  div_flags_t             i_flags,
  output logic                   o_valid,
  output logic [DW:0]            o_r,
  output logic [VW-1:0]          o_d,
  output logic [QW-1:0]          o_q,
  output logic [TW-1:0]          o_tag,
  output div_flags_t             o_flags
);

  localparam int unsigned RW = pr_width(DW);
  localparam int unsigned XW = (RW > VW) ? RW : VW;
  localparam int unsigned HI = QW - 1 - STAGE * BPS;

  logic [RW-1:0] w_r_nxt;
  logic [QW-1:0] w_q_nxt;

  logic          r_valid;
  logic [VW-1:0] r_d;
  logic [QW-1:0] r_q;
  logic [TW-1:0] r_tag;
  div_flags_t    r_flags;

  // BPS restoring steps, MSB first; overflow forces saturated quotient and zero remainder
  always_comb begin
    w_r_nxt = i_r;
    w_q_nxt = i_q;
    for (int unsigned b = 0; b < BPS; b++) begin
      if (XW'(w_r_nxt >> (HI - b)) >= XW'(i_d)) begin
        w_r_nxt = w_r_nxt - (RW'(i_d) << (HI - b));
        w_q_nxt = w_q_nxt | (QW'(1) << (HI - b));
      end
    end
    if (i_flags.ovf) begin
      w_q_nxt = '1;
      w_r_nxt = '0;
    end
  end

  // Stage registers; everything holds while the pipeline is stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_d     <= '0;
      r_q     <= '0;
      r_tag   <= '0;
      r_flags <= div_flags_t'(FLAG_NONE);
    end else if (i_en) begin
      r_valid <= i_valid;
      r_d     <= i_d;
      r_q     <= w_q_nxt;
      r_tag   <= i_tag;
      r_flags <= i_flags;
    end
  end

  if (KEEP_R) begin : g_r
    logic [RW-1:0] r_r;

    // Partial remainder register
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_r <= '0;
      end else if (i_en) begin
        r_r <= w_r_nxt;
      end
    end

    assign o_r = r_r;
  end else begin : g_no_r
    logic w_unused_r;
    assign w_unused_r = ^w_r_nxt;
    assign o_r        = '0;
  end

  assign o_valid = r_valid;
  assign o_d     = r_d;
  assign o_q     = r_q;
  assign o_tag   = r_tag;
  assign o_flags = r_flags;

endmodule

// File: rtl/param_pipe_divider.sv
// Fully pipelined unsigned divider with valid/ready flow control, tag
// passthrough and divide-by-zero / overflow flags.
// Define PIPE_DIV_REMAINDER_EN to build the remainder output (rem port).
module param_pipe_divider
  import pipe_div_pkg::*;
#(
  parameter int unsigned DW  = DEF_DW,
  parameter int unsigned VW  = DEF_VW,
  parameter int unsigned QW  = DEF_QW,
  parameter int unsigned BPS = DEF_BPS,
  parameter int unsigned TW  = DEF_TW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] q,
`ifdef PIPE_DIV_REMAINDER_EN
  output logic [VW-1:0] rem,
`endif
  output logic [TW-1:0] out_tag,
  output logic          div0,
  output logic          ovf
);

  localparam int unsigned S  = num_stages(QW, BPS);
  localparam int unsigned RW = pr_width(DW);
  localparam int unsigned XW = (RW > VW) ? RW : VW;
`ifdef PIPE_DIV_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic          w_adv;
  logic          w_div0;
  logic          w_ovf;
  logic [S:0]    w_valid;
  logic [RW-1:0] w_r     [S+1];
  logic [VW-1:0] w_d     [S+1];
  logic [QW-1:0] w_q     [S+1];
  logic [TW-1:0] w_tag   [S+1];
  div_flags_t    w_flags [S+1];
  logic          w_unused;

  // Single global advance: the whole pipe moves or the whole pipe holds
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage-0 classification of the incoming operation
  assign w_div0 = (divisor == '0);
  assign w_ovf  = !w_div0 && (XW'(dividend >> QW) >= XW'(divisor));

  assign w_valid[0] = in_valid;
  assign w_r[0]     = RW'(dividend);
  assign w_d[0]     = divisor;
  assign w_q[0]     = '0;
  assign w_tag[0]   = in_tag;
  assign w_flags[0] = w_div0 ? div_flags_t'(FLAG_DIV0)
                    : (w_ovf ? div_flags_t'(FLAG_OVF) : div_flags_t'(FLAG_NONE));

  for (genvar k = 0; k < S; k++) begin : g_stage
    pipe_div_stage #(
      .DW     (DW),
      .VW     (VW),
      .QW     (QW),
      .BPS    (BPS),
      .TW     (TW),
      .STAGE  (k),
      .KEEP_R ((k + 1 < S) || REM_EN)
    ) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .i_en    (w_adv),
      .i_valid (w_valid[k]),
      .i_r     (w_r[k]),
      .i_d     (w_d[k]),
      .i_q     (w_q[k]),
      .i_tag   (w_tag[k]),
      .i_flags (w_flags[k]),
      .o_valid (w_valid[k+1]),
      .o_r     (w_r[k+1]),
      .o_d     (w_d[k+1]),
      .o_q     (w_q[k+1]),
      .o_tag   (w_tag[k+1]),
      .o_flags (w_flags[k+1])
    );
  end

  // Last-stage registers are the outputs
  assign out_valid = w_valid[S];
  assign q         = w_q[S];
  assign out_tag   = w_tag[S];
  assign div0      = w_flags[S].div0;
  assign ovf       = w_flags[S].ovf;
`ifdef PIPE_DIV_REMAINDER_EN
  assign rem       = w_r[S][VW-1:0];
`endif

  // Divisor copy and upper remainder bits have no consumer after the last stage
  assign w_unused = ^{w_r[S], w_d[S]};

endmodule

// File: tb/tb_param_pipe_divider.sv
// Self-checking bench for param_pipe_divider against an arithmetic reference model.
// Honours PIPE_DIV_REMAINDER_EN for the rem port.
module tb_param_pipe_divider;

  localparam int unsigned DW = 28;
  localparam int unsigned VW = 20;
  localparam int unsigned QW = 8;
  localparam int unsigned TW = 4;
  parameter  int unsigned BPS = 1;
  localparam int SI = int'(QW / BPS);

  typedef struct packed {
    logic [QW-1:0] q;
    logic [VW-1:0] rem;
    logic [TW-1:0] tag;
    logic          div0;
    logic          ovf;
  } res_t;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] q;
`ifdef PIPE_DIV_REMAINDER_EN
  logic [VW-1:0] rem;
`endif
  logic [TW-1:0] out_tag;
  logic          div0;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  param_pipe_divider #(
    .DW(DW), .VW(VW), .QW(QW), .BPS(BPS), .TW(TW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
`ifdef PIPE_DIV_REMAINDER_EN
    .rem       (rem),
`endif
    .out_tag   (out_tag),
    .div0      (div0),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: plain integer division with the saturation rules
  function automatic res_t model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                 input logic [TW-1:0] t);
    res_t r;
    longint unsigned la, lb, lq;
    la = 64'(a);
    lb = 64'(b);
    r.tag  = t;
    r.div0 = 1'b0;
    r.ovf  = 1'b0;
    if (lb == 64'd0) begin
      r.q    = '1;
      r.rem  = a[VW-1:0];
      r.div0 = 1'b1;
    end else begin
      lq = la / lb;
      if (lq >= (64'd1 << QW)) begin
        r.q   = '1;
        r.rem = '0;
        r.ovf = 1'b1;
      end else begin
        r.q   = QW'(lq);
        r.rem = VW'(la % lb);
      end
    end
`ifndef PIPE_DIV_REMAINDER_EN
    r.rem = '0;
`endif
    return r;
  endfunction

  function automatic res_t cur_result();
    res_t r;
    r.q    = q;
`ifdef PIPE_DIV_REMAINDER_EN
    r.rem  = rem;
`else
    r.rem  = '0;
`endif
    r.tag  = out_tag;
    r.div0 = div0;
    r.ovf  = ovf;
    return r;
  endfunction

  task automatic test_reset();
    res_t got;
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    in_tag    = '0;
    #2 reset_n = 1'b0;
    #1;
    got = cur_result();
    checks++;
    if (out_valid !== 1'b0 || got !== res_t'(0)) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b q=%0d tag=%0d div0=%b ovf=%b expected all zero",
               out_valid, got.q, got.tag, got.div0, got.ovf);
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] av [4];
    logic [VW-1:0] bv [4];
    res_t          ex [4];
    res_t          got;
    logic          want;
    av[0] = DW'(100); bv[0] = VW'(5);
    av[1] = DW'(101); bv[1] = VW'(5);
    av[2] = DW'(21);  bv[2] = VW'(3);
    av[3] = DW'(300); bv[3] = VW'(3);
    for (int j = 0; j < 4; j++) ex[j] = model(av[j], bv[j], TW'(j + 1));
    for (int it = 0; it < SI + 6; it++) begin
      @(posedge clock); #1;
      out_ready = 1'b1;
      if (it < 4) begin
        in_valid = 1'b1; dividend = av[it]; divisor = bv[it]; in_tag = TW'(it + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      want = (it >= SI) && (it < SI + 4);
      checks++;
      if (out_valid !== want) begin
        failures++;
        $display("FAIL basic_valid cycle=%0d got=%b expected=%b", it, out_valid, want);
      end
      if (want && out_valid === 1'b1) begin
        got = cur_result();
        checks++;
        if (got !== ex[it-SI]) begin
          failures++;
          $display("FAIL basic_result idx=%0d got q=%0d rem=%0d tag=%0d d0=%b ov=%b expected q=%0d rem=%0d tag=%0d d0=%b ov=%b",
                   it - SI, got.q, got.rem, got.tag, got.div0, got.ovf,
                   ex[it-SI].q, ex[it-SI].rem, ex[it-SI].tag, ex[it-SI].div0, ex[it-SI].ovf);
        end
      end
    end
  endtask

  task automatic test_flags();
    logic [DW-1:0] av [8];
    logic [VW-1:0] bv [8];
    res_t          ex [8];
    res_t          got;
    logic          want;
    av[0] = DW'(1000);      bv[0] = VW'(3);
    av[1] = DW'(77);        bv[1] = VW'(0);
    av[2] = DW'(255);       bv[2] = VW'(1);
    av[3] = DW'(256);       bv[3] = VW'(1);
    av[4] = DW'(0);         bv[4] = VW'(5);
    av[5] = DW'(0);         bv[5] = VW'(0);
    av[6] = '1;             bv[6] = '1;
    av[7] = DW'(268435199); bv[7] = '1;
    for (int j = 0; j < 8; j++) ex[j] = model(av[j], bv[j], TW'(j + 8));
    for (int it = 0; it < SI + 10; it++) begin
      @(posedge clock); #1;
      out_ready = 1'b1;
      if (it < 8) begin
        in_valid = 1'b1; dividend = av[it]; divisor = bv[it]; in_tag = TW'(it + 8);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      want = (it >= SI) && (it < SI + 8);
      checks++;
      if (out_valid !== want) begin
        failures++;
        $display("FAIL flags_valid cycle=%0d got=%b expected=%b", it, out_valid, want);
      end
      if (want && out_valid === 1'b1) begin
        got = cur_result();
        checks++;
        if (got !== ex[it-SI]) begin
          failures++;
          $display("FAIL flags_result idx=%0d got q=%0d rem=%0d tag=%0d d0=%b ov=%b expected q=%0d rem=%0d tag=%0d d0=%b ov=%b",
                   it - SI, got.q, got.rem, got.tag, got.div0, got.ovf,
                   ex[it-SI].q, ex[it-SI].rem, ex[it-SI].tag, ex[it-SI].div0, ex[it-SI].ovf);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    res_t sb[$];
    res_t got, ex;
    int   n_in = 0;
    int   n_stall = 0;
    int   cyc = 0;
    for (int it = 0; it < SI + 14; it++) begin
      @(posedge clock); #1;
      out_ready = 1'b0;
      if (it < 4) begin
        in_valid = 1'b1;
        dividend = DW'($urandom_range(0, 200000));
        divisor  = VW'($urandom_range(1, 1000));
        in_tag   = TW'(it + 3);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      if (in_valid && in_ready === 1'b1) begin
        sb.push_back(model(dividend, divisor, in_tag));
        n_in++;
      end
      if (out_valid === 1'b1) begin
        n_stall++;
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready cycle=%0d got=%b expected=0", it, in_ready);
        end
        got = cur_result();
        checks++;
        if (sb.size() == 0 || got !== sb[0]) begin
          failures++;
          $display("FAIL bp_hold cycle=%0d got q=%0d tag=%0d queued=%0d", it, got.q, got.tag, sb.size());
        end
      end
    end
    checks++;
    if (n_in != 4 || n_stall < 10) begin
      failures++;
      $display("FAIL bp_counts got accepted=%0d stalled=%0d expected 4 and >=10", n_in, n_stall);
    end
    while (sb.size() != 0 && cyc < 4 * SI + 16) begin
      @(posedge clock); #1;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clock);
      cyc++;
      if (out_valid === 1'b1) begin
        got = cur_result();
        ex  = sb.pop_front();
        checks++;
        if (got !== ex) begin
          failures++;
          $display("FAIL bp_drain got q=%0d tag=%0d expected q=%0d tag=%0d", got.q, got.tag, ex.q, ex.tag);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL bp_timeout got %0d results still missing expected 0", sb.size());
    end
    for (int it = 0; it < SI + 2; it++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_duplicate cycle=%0d got out_valid=%b expected=0", it, out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    res_t got;
    for (int it = 0; it < 3; it++) begin
      @(posedge clock); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      dividend  = DW'($urandom_range(0, 5000));
      divisor   = VW'($urandom_range(1, 50));
      in_tag    = TW'(it + 1);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    got = cur_result();
    checks++;
    if (out_valid !== 1'b0 || got !== res_t'(0)) begin
      failures++;
      $display("FAIL midreset_outputs got valid=%b q=%0d tag=%0d div0=%b ovf=%b expected all zero",
               out_valid, got.q, got.tag, got.div0, got.ovf);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int it = 0; it < SI + 4; it++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset_stale cycle=%0d got out_valid=%b in_ready=%b expected 0 1",
                 it, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random(input int n_ops);
    res_t sb[$];
    res_t got, ex, prev;
    logic prev_stall = 1'b0;
    int   issued = 0;
    int   cyc = 0;
    int   mode;
    logic [VW-1:0] b;
    prev = '0;
    while ((issued < n_ops || sb.size() != 0) && cyc < 40 * n_ops) begin
      @(posedge clock); #1;
      cyc++;
      mode     = int'($urandom_range(0, 7));
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      case (mode)
        0: divisor  = '0;
        1: divisor  = VW'(1);
        2: divisor  = '1;
        3: dividend = '0;
        4: begin
          b        = VW'($urandom_range(1, 4095));
          divisor  = b;
          dividend = DW'(64'(b) * 64'($urandom_range(0, 255)) + 64'($urandom_range(0, 32'(b) - 1)));
        end
        default: ;
      endcase
      in_tag    = TW'($urandom);
      in_valid  = (issued < n_ops) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      got = cur_result();
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || got !== prev) begin
          failures++;
          $display("FAIL rand_stable cycle=%0d got valid=%b q=%0d tag=%0d expected held q=%0d tag=%0d",
                   cyc, out_valid, got.q, got.tag, prev.q, prev.tag);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rand_extra cycle=%0d got q=%0d tag=%0d expected no result", cyc, got.q, got.tag);
        end else begin
          ex = sb.pop_front();
          if (got !== ex) begin
            failures++;
            $display("FAIL rand_result cycle=%0d got q=%0d rem=%0d tag=%0d d0=%b ov=%b expected q=%0d rem=%0d tag=%0d d0=%b ov=%b",
                     cyc, got.q, got.rem, got.tag, got.div0, got.ovf, ex.q, ex.rem, ex.tag, ex.div0, ex.ovf);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        sb.push_back(model(dividend, divisor, in_tag));
        issued++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev       = got;
    end
    in_valid = 1'b0;
    checks++;
    if (issued < n_ops || sb.size() != 0) begin
      failures++;
      $display("FAIL rand_timeout got issued=%0d pending=%0d expected %0d and 0", issued, sb.size(), n_ops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_backpressure();
    test_reset_midflight();
    test_random(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
